// File: rtl/btime_input_pkg.sv
// Shared joystick bit map and FSM state types for the Burger Time input stage.
package btime_input_pkg;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;
    localparam int unsigned JOY_COIN   = 7;
    localparam int unsigned JOY_PAUSE  = 8;

    typedef enum logic [1:0] {
        C_IDLE,
        C_PULSE,
        C_HOLD
    } coin_state_t;

    typedef enum logic [1:0] {
        P_RUN,
        P_ENTER,
        P_PAUSED,
        P_EXIT
    } pause_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Turns a coin button press into one fixed-width pulse; the button must be
// released before another pulse can start.
module coin_pulser
    import btime_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 1200000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_btn,
    output logic coin
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(COIN_PULSE - 1);

    coin_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             btn_prev;
    logic             primed;
    logic             btn_rise;

    // A button already held when reset releases is not a new press.
    assign btn_rise = primed & coin_btn & ~btn_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= C_IDLE;
            cnt      <= '0;
            btn_prev <= 1'b0;
            primed   <= 1'b0;
            coin     <= 1'b0;
        end else begin
            btn_prev <= coin_btn;
            primed   <= 1'b1;
            case (state)
                C_IDLE: begin
                    if (btn_rise) begin
                        state <= C_PULSE;
                        cnt   <= '0;
                        coin  <= 1'b1;
                    end
                end
                C_PULSE: begin
                    if (cnt == LAST) begin
                        state <= C_HOLD;
                        coin  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                C_HOLD: begin
                    coin <= 1'b0;
                    if (!coin_btn) begin
                        state <= C_IDLE;
                    end
                end
                default: begin
                    state <= C_IDLE;
                    coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btime_input_ctrl.sv
// Burger Time input conditioning: joystick merge, coin shaping, frame-aligned pause
// and dim-after-timeout. Define BTIME_AUTOFIRE_EN to add the autofire option.
module btime_input_ctrl
    import btime_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 1200000,
    parameter int unsigned DIM_TICKS  = 120000000,
    parameter int unsigned CNT_W      = 32
`ifdef BTIME_AUTOFIRE_EN
    ,
    parameter int unsigned AF_HALF    = 600000
`endif
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        osd_status,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    input  logic        vblank,
`ifdef BTIME_AUTOFIRE_EN
    input  logic        autofire_en,
`endif
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        fire,
    output logic        start1,
    output logic        start2,
    output logic        coin,
    output logic        pause,
    output logic        user_paused,
    output logic        dim_video
);

    localparam logic [CNT_W-1:0] DIM_MAX = CNT_W'(DIM_TICKS);

    logic [15:0] joy;
    logic        unused_joy;

    assign joy        = joystick_0 | joystick_1;
    assign unused_joy = ^joy[15:9];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            up     <= 1'b0;
            down   <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            start1 <= 1'b0;
            start2 <= 1'b0;
        end else begin
            up     <= joy[JOY_UP];
            down   <= joy[JOY_DOWN];
            left   <= joy[JOY_LEFT];
            right  <= joy[JOY_RIGHT];
            start1 <= joy[JOY_START1];
            start2 <= joy[JOY_START2];
        end
    end

`ifdef BTIME_AUTOFIRE_EN
    localparam logic [CNT_W-1:0] AF_LAST = CNT_W'(AF_HALF - 1);

    logic [CNT_W-1:0] af_cnt;
    logic             af_active;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fire      <= 1'b0;
            af_cnt    <= '0;
            af_active <= 1'b0;
        end else if (autofire_en && joy[JOY_FIRE]) begin
            if (!af_active) begin
                af_active <= 1'b1;
                af_cnt    <= '0;
                fire      <= 1'b1;
            end else if (af_cnt == AF_LAST) begin
                af_cnt <= '0;
                fire   <= ~fire;
            end else begin
                af_cnt <= af_cnt + CNT_W'(1);
            end
        end else begin
            af_active <= 1'b0;
            af_cnt    <= '0;
            fire      <= joy[JOY_FIRE];
        end
    end
`else
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fire <= 1'b0;
        end else begin
            fire <= joy[JOY_FIRE];
        end
    end
`endif

    coin_pulser #(
        .COIN_PULSE(COIN_PULSE),
        .CNT_W     (CNT_W)
    ) u_coin_pulser (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .coin_btn(joy[JOY_COIN]),
        .coin    (coin)
    );

    pause_state_t     pstate;
    pause_state_t     pstate_d;
    logic             pause_prev;
    logic             vblank_prev;
    logic             primed;
    logic             pause_rise;
    logic             vblank_rise;
    logic             user_paused_d;
    logic [CNT_W-1:0] dim_cnt;
    logic [CNT_W-1:0] dim_cnt_d;

    assign pause_rise  = primed & joy[JOY_PAUSE] & ~pause_prev;
    assign vblank_rise = vblank & ~vblank_prev;

    // A pause press takes priority over a coincident vblank edge.
    always_comb begin
        pstate_d = pstate;
        case (pstate)
            P_RUN:    if (pause_rise) pstate_d = P_ENTER;
            P_ENTER:  if (pause_rise) pstate_d = P_RUN;
                      else if (vblank_rise) pstate_d = P_PAUSED;
            P_PAUSED: if (pause_rise) pstate_d = P_EXIT;
            P_EXIT:   if (pause_rise) pstate_d = P_PAUSED;
                      else if (vblank_rise) pstate_d = P_RUN;
            default:  pstate_d = P_RUN;
        endcase
    end

    assign user_paused_d = (pstate_d == P_PAUSED) || (pstate_d == P_EXIT);

    always_comb begin
        dim_cnt_d = '0;
        if (user_paused_d) begin
            dim_cnt_d = (dim_cnt == DIM_MAX) ? dim_cnt : dim_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pstate      <= P_RUN;
            pause_prev  <= 1'b0;
            vblank_prev <= 1'b0;
            primed      <= 1'b0;
            user_paused <= 1'b0;
            pause       <= 1'b0;
            dim_cnt     <= '0;
            dim_video   <= 1'b0;
        end else begin
            pstate      <= pstate_d;
            pause_prev  <= joy[JOY_PAUSE];
            vblank_prev <= vblank;
            primed      <= 1'b1;
            user_paused <= user_paused_d;
            pause       <= user_paused_d | hs_access | (osd_status & osd_pause_en);
            dim_cnt     <= dim_cnt_d;
            // Gated by the next pause state so dim drops together with user_paused.
            dim_video   <= user_paused_d && (dim_cnt == DIM_MAX);
        end
    end

endmodule

// File: tb/tb_btime_input_ctrl.sv
// Directed bench for btime_input_ctrl with short coin and dim timers.
module tb_btime_input_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        osd_status;
    logic        osd_pause_en;
    logic        hs_access;
    logic        vblank;
`ifdef BTIME_AUTOFIRE_EN
    logic        autofire_en;
`endif
    logic        up, down, left, right, fire, start1, start2;
    logic        coin, pause, user_paused, dim_video;

    int checks;
    int failures;

    btime_input_ctrl #(
        .COIN_PULSE(4),
        .DIM_TICKS (10),
        .CNT_W     (8)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .osd_status  (osd_status),
        .osd_pause_en(osd_pause_en),
        .hs_access   (hs_access),
        .vblank      (vblank),
`ifdef BTIME_AUTOFIRE_EN
        .autofire_en (autofire_en),
`endif
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .fire        (fire),
        .start1      (start1),
        .start2      (start2),
        .coin        (coin),
        .pause       (pause),
        .user_paused (user_paused),
        .dim_video   (dim_video)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    int highs;
    int rises;
    int seen;
    logic prev_coin;

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        joystick_0   = '0;
        joystick_1   = '0;
        osd_status   = 1'b0;
        osd_pause_en = 1'b0;
        hs_access    = 1'b0;
        vblank       = 1'b0;
`ifdef BTIME_AUTOFIRE_EN
        autofire_en  = 1'b0;
`endif
        step(3);
        check_eq("rst_outputs", 32'({up, down, left, right, fire, start1, start2,
                                     coin, pause, user_paused, dim_video}), 0);
        reset_n = 1'b1;
        step(2);
        check_eq("idle_outputs", 32'({up, down, left, right, fire, start1, start2,
                                      coin, pause, user_paused, dim_video}), 0);

        // Direction and button latency, merge across both joysticks
        joystick_1[3] = 1'b1;
        step(1);
        check_eq("up_latency", 32'(up), 1);
        check_eq("down_quiet", 32'(down), 0);
        joystick_1 = '0;
        joystick_0[4] = 1'b1;
        joystick_1[5] = 1'b1;
        step(1);
        check_eq("up_release", 32'(up), 0);
        check_eq("fire_start1", 32'({fire, start1, start2}), 3'b110);
        joystick_0 = '0;
        joystick_1 = '0;
        step(2);

        // Coin held 20 cycles -> one 4-cycle pulse
        joystick_0[7] = 1'b1;
        highs = 0;
        rises = 0;
        prev_coin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i == 0) check_eq("coin_first", 32'(coin), 1);
            if (coin) highs++;
            if (coin && !prev_coin) rises++;
            prev_coin = coin;
        end
        check_eq("coin_width", 32'(highs), 4);
        check_eq("coin_pulses", 32'(rises), 1);
        joystick_0 = '0;
        step(2);
        joystick_0[7] = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (coin) highs++;
        end
        check_eq("coin_width2", 32'(highs), 4);
        joystick_0 = '0;
        step(2);

        // Pause request, frame-aligned entry 30 cycles later, dim timing
        joystick_0[8] = 1'b1;
        step(1);
        joystick_0 = '0;
        seen = 0;
        for (int i = 0; i < 29; i++) begin
            step(1);
            if (user_paused || pause) seen++;
        end
        check_eq("pause_wait_vbl", 32'(seen), 0);
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        check_eq("user_paused_on", 32'(user_paused), 1);
        check_eq("pause_on", 32'(pause), 1);
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (dim_video) seen++;
        end
        check_eq("dim_early", 32'(seen), 0);
        step(1);
        check_eq("dim_on", 32'(dim_video), 1);
        step(5);
        check_eq("dim_hold", 32'(dim_video), 1);
        joystick_0[8] = 1'b1;
        step(1);
        joystick_0 = '0;
        step(3);
        check_eq("exit_pending", 32'({user_paused, dim_video}), 2'b11);
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        check_eq("unpause", 32'({user_paused, dim_video, pause}), 0);
        step(1);

        // hiscore and OSD pause sources
        hs_access = 1'b1;
        step(1);
        check_eq("hs_pause", 32'({pause, user_paused}), 2'b10);
        hs_access = 1'b0;
        step(1);
        check_eq("hs_release", 32'(pause), 0);
        osd_status = 1'b1;
        step(1);
        check_eq("osd_no_en", 32'(pause), 0);
        osd_pause_en = 1'b1;
        step(1);
        check_eq("osd_en", 32'(pause), 1);
        osd_status = 1'b0;
        osd_pause_en = 1'b0;
        step(1);

        // Cancelled request, then a pause edge coincident with vblank
        joystick_0[8] = 1'b1;
        step(1);
        joystick_0 = '0;
        step(1);
        joystick_0[8] = 1'b1;
        step(1);
        joystick_0 = '0;
        step(1);
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        check_eq("cancel", 32'({user_paused, pause}), 0);
        step(1);
        joystick_0[8] = 1'b1;
        vblank = 1'b1;
        step(1);
        check_eq("coincident", 32'(user_paused), 0);
        joystick_0 = '0;
        vblank = 1'b0;
        step(1);
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        check_eq("coincident_enter", 32'(user_paused), 1);

        // Async reset during a coin pulse while paused
        joystick_0[7] = 1'b1;
        step(1);
        check_eq("coin_before_rst", 32'({coin, pause}), 2'b11);
        reset_n = 1'b0;
        #2;
        check_eq("rst_async", 32'({coin, pause, user_paused}), 0);
        step(1);
        reset_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (coin) highs++;
        end
        check_eq("held_after_rst", 32'(highs), 0);
        joystick_0 = '0;
        step(1);
        joystick_0[7] = 1'b1;
        step(1);
        check_eq("repress_after_rst", 32'(coin), 1);
        joystick_0 = '0;
        step(5);

        // Async reset during P_ENTER drops the pending request
        joystick_0[8] = 1'b1;
        step(1);
        joystick_0 = '0;
        step(1);
        reset_n = 1'b0;
        #2;
        check_eq("rst_enter", 32'({pause, user_paused}), 0);
        step(1);
        reset_n = 1'b1;
        step(2);
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        check_eq("enter_aborted", 32'({user_paused, pause}), 0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btime_input_ctrl.md
Name: btime_input_ctrl

Overview:
- Input-conditioning stage directly upstream of the burger_time core and video path in the Burger Time MiSTer top level.
- Merges `joystick_0`/`joystick_1` into the player controls.
- Shapes coin presses into fixed-width pulses.
- Owns the pause toggle, frame-aligned pause entry/exit, composite pause output and dim-after-timeout flag, replacing ad-hoc top-level logic.

Parameters:
- COIN_PULSE, 1200000, coin output width in clk_sys cycles (100 ms @ 12 MHz); must be ≥1.
- DIM_TICKS, 120000000, paused cycles before dim asserts (10 s @ 12 MHz); must be ≥1.
- CNT_W, 32, width of the coin and dim counters.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- joystick_0  in  16  hps_io joystick 0.
- joystick_1  in  16  hps_io joystick 1.
- osd_status  in  1  OSD open.
- osd_pause_en  in  1  1 = pause while OSD open.
- hs_access  in  1  hiscore module requests RAM (immediate pause).
- vblank  in  1  core vertical blank.
- up, down, left, right, fire  out  1 each  registered controls.
- start1, start2  out  1 each  registered start buttons.
- coin  out  1  shaped coin pulse.
- pause  out  1  composite pause to core.
- user_paused  out  1  frame-aligned user pause state.
- dim_video  out  1  dim request to the video path.

Behaviour:
- Async reset: all outputs 0, both counters 0, FSMs in reset state, edge registers 0.
- Merge: `joy = joystick_0 | joystick_1`.
  - Bit map: 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2, 7 coin, 8 pause.
- Directions, fire, start1, start2: registered copies of `joy` bits, latency 1 cycle, no filtering.
- Coin FSM:
  - C_IDLE: on `joy[7]` rising edge (prev 0, now 1) -> C_PULSE, counter cleared.
  - C_PULSE: `coin`=1 for exactly COIN_PULSE cycles (coin rises the cycle after the edge is detected), then -> C_HOLD.
  - C_HOLD: `coin`=0; -> C_IDLE only once `joy[7]`=0.
  - Holding coin yields one pulse. Release during C_PULSE does not shorten the pulse.
- Pause FSM (states P_RUN, P_ENTER, P_PAUSED, P_EXIT):
  - A `joy[8]` rising edge toggles the request: P_RUN -> P_ENTER, P_PAUSED -> P_EXIT.
  - A second edge while pending cancels: P_ENTER -> P_RUN, P_EXIT -> P_PAUSED.
  - P_ENTER -> P_PAUSED and P_EXIT -> P_RUN occur on a `vblank` rising edge only.
  - `user_paused` = 1 in P_PAUSED and P_EXIT.
  - A vblank edge and a pause edge in the same cycle: the pause edge wins (the toggle is applied, the vblank edge is ignored that cycle).
- `pause` (registered, 1 cycle) = `user_paused | hs_access | (osd_status & osd_pause_en)`. `hs_access` is never frame-gated.
- Dim counter:
  - Increments while `user_paused`, saturating at DIM_TICKS.
  - Cleared the cycle `user_paused` is 0.
  - `dim_video` = (counter == DIM_TICKS), registered.
- Reset mid-operation aborts any coin pulse or pending pause immediately; outputs return to reset values.

Optional Feature:
- BTIME_AUTOFIRE_EN
- Defined:
  - Adds input `autofire_en` (1 bit) and parameter AF_HALF (default 600000 cycles).
  - While `autofire_en` & `joy[4]`, `fire` toggles every AF_HALF cycles, starting at 1 the cycle after press.
  - Release forces `fire`=0 and resets the phase.
- Undefined: no port, no parameter; `fire` is the plain registered `joy[4]`.

Decomposition:
- Package btime_input_pkg:
  - joystick bit-index constants JOY_RIGHT..JOY_PAUSE;
  - coin_state_t {C_IDLE, C_PULSE, C_HOLD};
  - pause_state_t {P_RUN, P_ENTER, P_PAUSED, P_EXIT}.
- One sub-module, coin_pulser: edge detect, counter and coin FSM, parameterised by COIN_PULSE/CNT_W. Everything else stays in the top.

Test Plan (COIN_PULSE=4, DIM_TICKS=10, CNT_W=8):
- Reset release, all inputs 0 -> all outputs 0. `joystick_1[3]`=1 -> `up`=1 one cycle later.
- `joystick_0[7]` held 20 cycles -> `coin` high exactly 4 cycles, one pulse. Release then re-press -> second 4-cycle pulse.
- `joy[8]` pulse, vblank rises 30 cycles later:
  - `user_paused`/`pause` stay 0 until that edge, then 1;
  - `dim_video` rises exactly 10 cycles after `user_paused` rises;
  - second `joy[8]` pulse plus next vblank edge -> `user_paused`=0 and `dim_video`=0 together.
- `hs_access`=1 with FSM in P_RUN -> `pause`=1 next cycle, `user_paused` stays 0. `osd_status`=1, `osd_pause_en`=0 -> `pause` stays 0.
- Two `joy[8]` edges before any vblank -> FSM back to P_RUN, no pause. Pause edge coincident with vblank edge -> P_ENTER, not P_PAUSED.
- `reset_n` low during C_PULSE and during P_ENTER -> `coin`=0 and `pause`=0 immediately (async). After release with coin still held, no pulse until a new rising edge.
